// File: rtl/ps2_scancode_controller_if.sv
// CPU-side bus of the PS/2 scan-code controller: address, read strobe, read data, irq.
// Latency: data is combinational from address; pops/clears take effect at the next edge.
// Backpressure: none; reads are single-cycle strobes, irq tells the CPU data is waiting.
interface ps2_scancode_controller_if;
  logic [13:0] address;
  logic        read_en;
  wire  [63:0] data;
  logic        irq;

  modport master (
    output address,
    output read_en,
    input  data,
    input  irq
  );

  modport slave (
    input  address,
    input  read_en,
    output data,
    output irq
  );
endinterface

// File: rtl/ps2_scancode_controller.sv
// PS/2 keyboard receiver: oversampled frame decoder, odd-parity check, 8-deep scan-code FIFO, status regs.
// Latency: byte visible in FIFO (irq high) 1 cycle after the stop-bit fall pulse, +2 cycles of sync delay.
// Backpressure: none toward the keyboard; a push into a full FIFO drops the byte and sets overflow.
// Optional: define PS2_BREAK_FILTER_EN to suppress 8'hF0 break prefixes and the byte following each.
module ps2_scancode_controller #(
  parameter logic [13:0] DATA_ADDRESS    = 14'h3fff,
  parameter logic [13:0] STATUS_ADDRESS  = 14'h3ffe,
  parameter int          FIFO_DEPTH_LOG2 = 3,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd50000
) (
  input  logic                      system_clk,
  input  logic                      reset,
  input  logic                      PS2_clk,
  input  logic                      PS2_data,
  ps2_scancode_controller_if.slave  bus
);

  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t state, state_nxt;

  // synchronizer and edge detect
  logic clk_s1, clk_s2, clk_prev;
  logic data_s1, data_s2;
  logic fall;

  // frame datapath
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        parity_bit;
  logic        parity_ok;
  logic [15:0] to_cnt;

  // frame events from the FSM
  logic frame_done;
  logic frame_bad;
  logic timeout;
  logic push_req;

  // FIFO
  logic [7:0]                 mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]              count;
  logic                       empty, full;
  logic                       push_ok, pop;

  // status
  logic       frame_error;
  logic       overflow;
  logic [7:0] err_count;
  logic       err_evt;
  logic       stat_clr;
  logic       data_sel, stat_sel;
  logic [3:0] cnt4;
  logic [63:0] data_word, status_word;

  // two-flop synchronizers plus a history flop for falling-edge detection; idle-high lines reset to 1
  always_ff @(posedge system_clk) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= PS2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= PS2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall      = clk_prev & ~clk_s2;
  assign parity_ok = ^{shift_reg, parity_bit};

  // FSM state register
  always_ff @(posedge system_clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM next state and frame-completion events; a stalled partial frame is aborted by the timeout
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    frame_bad  = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE:   if (fall && !data_s2) state_nxt = DATA;
      DATA:   if (fall && bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY: if (fall) state_nxt = STOP;
      STOP: begin
        if (fall) begin
          state_nxt = IDLE;
          if (data_s2 && parity_ok) frame_done = 1'b1;
          else                      frame_bad  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (state != IDLE && !fall && to_cnt == TIMEOUT_CYCLES - 16'd1) begin
      state_nxt = IDLE;
      timeout   = 1'b1;
    end
  end

  // bit capture: data bits LSB first, then the parity bit; a timeout discards the partial byte
  always_ff @(posedge system_clk) begin
    if (reset) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'd0;
      parity_bit <= 1'b0;
    end else if (timeout) begin
      bit_cnt    <= 3'd0;
      shift_reg  <= 8'd0;
    end else if (fall) begin
      case (state)
        IDLE:   bit_cnt <= 3'd0;
        DATA: begin
          shift_reg[bit_cnt] <= data_s2;
          bit_cnt            <= bit_cnt + 3'd1;
        end
        PARITY: parity_bit <= data_s2;
        default: ;
      endcase
    end
  end

  // inactivity counter: runs only while a frame is in progress, restarts on every PS/2 fall
  always_ff @(posedge system_clk) begin
    if (reset)                                 to_cnt <= 16'd0;
    else if (state == IDLE || fall || timeout) to_cnt <= 16'd0;
    else                                       to_cnt <= to_cnt + 16'd1;
  end

`ifdef PS2_BREAK_FILTER_EN
  logic break_pending;

  // break filter: a valid F0 arms the filter, the next valid byte is swallowed; errors disarm it
  always_ff @(posedge system_clk) begin
    if (reset)                    break_pending <= 1'b0;
    else if (frame_bad || timeout) break_pending <= 1'b0;
    else if (frame_done) begin
      if (break_pending)            break_pending <= 1'b0;
      else if (shift_reg == 8'hF0) break_pending <= 1'b1;
    end
  end

  assign push_req = frame_done && !break_pending && (shift_reg != 8'hF0);
`else
  assign push_req = frame_done;
`endif

  // CPU decode
  assign data_sel = (bus.address == DATA_ADDRESS);
  assign stat_sel = (bus.address == STATUS_ADDRESS);

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign push_ok = push_req && !full;
  assign pop     = bus.read_en && data_sel && !empty;

  // FIFO storage write port
  always_ff @(posedge system_clk) begin
    if (push_ok) mem[wr_ptr] <= shift_reg;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge system_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign err_evt  = frame_bad | timeout;
  assign stat_clr = bus.read_en && stat_sel;

  // sticky error flags: cleared by a status read, but an error in the same cycle keeps the flag set
  always_ff @(posedge system_clk) begin
    if (reset) begin
      frame_error <= 1'b0;
      overflow    <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      if (err_evt)       frame_error <= 1'b1;
      else if (stat_clr) frame_error <= 1'b0;

      if (push_req && full) overflow <= 1'b1;
      else if (stat_clr)    overflow <= 1'b0;

      if (err_evt && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end

  // read mux: fields are packed upward from bit 0, so err_count sits at [27:20]
  assign cnt4        = 4'(count);
  assign data_word   = empty ? 64'd0 : {56'd0, mem[rd_ptr]};
  assign status_word = {36'd0, err_count, 8'd0, 3'd0, overflow, frame_error, full, empty, 1'b0, cnt4};

  assign bus.data = data_sel ? data_word :
                    stat_sel ? status_word : 64'bz;
  assign bus.irq  = ~empty;

endmodule
